mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage pipeline.
- Variable-latency memory uses a req/ack handshake. Requesters see level-sensitive req and a one-cycle ready; the pipeline stalls while its port's ready is low.
- Data port has priority, bounded by an anti-starvation limit so fetch always progresses.
- Supports cancellation of an in-flight fetch on branch misprediction or exception flush.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified memory port arbiter.
// Holds the arbiter FSM state encoding and the default width constants.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_t;

   localparam int ARB_ADDR_W       = 32;
   localparam int ARB_DATA_W       = 32;
   localparam int ARB_MAX_DM_BURST = 4;
   localparam int STREAK_W         = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority rule between fetch and data ports for the memory arbiter.
// Ports: if_req, if_cancel, dm_req, dm_streak, max in; grant_if, grant_dm out.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic                if_req,
   input  logic                if_cancel,
   input  logic                dm_req,
   input  logic [STREAK_W-1:0] dm_streak,
   input  logic [STREAK_W-1:0] max,
   output logic                grant_if,
   output logic                grant_dm
);

   logic starving;

   // Data wins unless a waiting fetch has already been passed over
   // max times in a row.
   assign starving = if_req & (dm_streak == max);
   assign grant_dm = dm_req & ~starving;
   assign grant_if = ~grant_dm & if_req & ~if_cancel;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory between the fetch port and the load/store port.
// Ports: clk, rst; if_* fetch port; dm_* data port; mem_* memory side;
// conflict_cycles counts cycles where both ports request but one must wait.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int MAX_DM_BURST = ARB_MAX_DM_BURST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_cancel,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_ready,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       conflict_cycles
);

   localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_DM_BURST);

   arb_state_t          state;
   logic                cancelled;
   logic [STREAK_W-1:0] dm_streak;
   logic                pick_if;
   logic                pick_dm;
   logic                grant_if;
   logic                grant_dm;
   logic                both_req;

   mem_arb_pick u_pick (
      .if_req    (if_req),
      .if_cancel (if_cancel),
      .dm_req    (dm_req),
      .dm_streak (dm_streak),
      .max       (MAX_S),
      .grant_if  (pick_if),
      .grant_dm  (pick_dm)
   );

   assign grant_if = pick_if & (state == IDLE);
   assign grant_dm = pick_dm & (state == IDLE);

   // A flush either before or coincident with the ack kills the fetch.
   assign if_ready = mem_ack & (state == BUSY_IF)
                   & ~cancelled & ~if_cancel;
   assign dm_ready = mem_ack & (state == BUSY_DM);
   assign if_rdata = mem_rdata;
   assign dm_rdata = mem_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cancelled <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               // mem_ack is ignored here, which also drops any
               // response left over from before a reset.
               cancelled <= 1'b0;
               if (grant_dm) begin
                  state     <= BUSY_DM;
                  mem_req   <= 1'b1;
                  mem_we    <= dm_we;
                  mem_addr  <= dm_addr;
                  mem_wdata <= dm_wdata;
               end else if (grant_if) begin
                  state     <= BUSY_IF;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
               end
            end
            BUSY_IF: begin
               if (mem_ack) begin
                  state     <= IDLE;
                  mem_req   <= 1'b0;
                  cancelled <= 1'b0;
               end else if (if_cancel) begin
                  cancelled <= 1'b1;
               end
            end
            BUSY_DM: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

   // Consecutive data grants seen by a waiting fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dm_streak <= '0;
      end else if (!if_req || grant_if) begin
         dm_streak <= '0;
      end else if (grant_dm && dm_streak != MAX_S) begin
         dm_streak <= dm_streak + 1'b1;
      end
   end

   // With both requesting, one port is always waiting: either both
   // sit in IDLE behind the grant, or one waits on the other's access.
   assign both_req = if_req & dm_req
                   & ((state == IDLE) | (state == BUSY_IF)
                      | (state == BUSY_DM));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cycles <= '0;
      end else if (both_req) begin
         conflict_cycles <= conflict_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter.
// Drives both requesters and a variable-latency memory, checks vs model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_cancel, if_ready;
   logic [31:0] if_addr, if_rdata;
   logic        dm_req, dm_we, dm_ready;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [31:0] conflict_cycles;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
      .if_ready(if_ready), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .conflict_cycles(conflict_cycles)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   logic [31:0] dev_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   int lat = 1;
   bit rand_lat = 0;
   int mcnt = 0;
   int cur_lat = 1;
   bit stray = 0;
   int conf_model = 0;

   logic        s_if_ready, s_dm_ready, s_mem_req, s_mem_we, s_mem_ack;
   logic [31:0] s_mem_addr, s_mem_wdata, s_if_rdata, s_dm_rdata, s_conf;

   function automatic logic [31:0] dev_rd(logic [31:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] ref_rd(logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: memory responds, outputs sampled at negedge,
   // returns 1 time unit after the next rising edge.
   task automatic cyc();
      if (stray) begin
         mem_ack   = 1'b1;
         mem_rdata = 32'hBAD0_BAD0;
      end else if (mem_req) begin
         mcnt++;
         if (mcnt == 1)
            cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
         mem_ack   = (mcnt == cur_lat);
         mem_rdata = mem_ack ? dev_rd(mem_addr) : $urandom;
      end else begin
         mcnt      = 0;
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
      end
      if (if_req && dm_req) conf_model++;
      @(negedge clk);
      s_if_ready  = if_ready;
      s_dm_ready  = dm_ready;
      s_mem_req   = mem_req;
      s_mem_we    = mem_we;
      s_mem_ack   = mem_ack;
      s_mem_addr  = mem_addr;
      s_mem_wdata = mem_wdata;
      s_if_rdata  = if_rdata;
      s_dm_rdata  = dm_rdata;
      s_conf      = conflict_cycles;
      if (mem_ack && mem_req && mem_we) dev_mem[mem_addr] = mem_wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req = 0; if_cancel = 0; if_addr = 0;
      dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      mcnt = 0;
      conf_model = 0;
   endtask

   initial begin
      logic [31:0] gq[$];
      logic [31:0] expg [6];
      logic [31:0] prev_addr;
      bit prev_req;
      int first_if;
      int w;
      bit f_act, d_act;
      int f_wait, max_wait;

      // Reset values
      idle_inputs();
      mem_ack = 0; mem_rdata = 0;
      rst = 1'b1;
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_dm_ready", dm_ready, 0);
      chk("rst_conf", conflict_cycles, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: single fetch, latency 3
      dev_mem[32'h40] = 32'h00A00093;
      ref_mem[32'h40] = 32'h00A00093;
      lat = 3; if_req = 1; if_addr = 32'h40;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("t1_mem_req_c%0d", i), s_mem_req, (i >= 1 && i <= 3));
         chk($sformatf("t1_if_ready_c%0d", i), s_if_ready, (i == 3));
         if (i == 1) chk("t1_mem_addr", s_mem_addr, 32'h40);
         if (i == 3) begin
            chk("t1_if_rdata", s_if_rdata, 32'h00A00093);
            if_req = 0;
         end
      end

      // 2: simultaneous store and fetch, latency 1
      do_reset();
      lat = 1;
      if_req = 1; if_addr = 32'h44;
      dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD;
      cyc();
      chk("t2_c0_mem_req", s_mem_req, 0);
      cyc();
      chk("t2_c1_mem_req", s_mem_req, 1);
      chk("t2_c1_mem_we", s_mem_we, 1);
      chk("t2_c1_mem_addr", s_mem_addr, 32'h100);
      chk("t2_c1_mem_wdata", s_mem_wdata, 32'hDEAD);
      chk("t2_c1_dm_ready", s_dm_ready, 1);
      chk("t2_c1_if_ready", s_if_ready, 0);
      ref_mem[32'h100] = 32'hDEAD;
      dm_req = 0; dm_we = 0;
      cyc();
      chk("t2_c2_dead", s_mem_req, 0);
      cyc();
      chk("t2_c3_mem_we", s_mem_we, 0);
      chk("t2_c3_mem_addr", s_mem_addr, 32'h44);
      chk("t2_c3_if_ready", s_if_ready, 1);
      chk("t2_c3_if_rdata", s_if_rdata, ref_rd(32'h44));
      if_req = 0;
      cyc();
      chk("t2_conf", s_conf, 2);
      chk("t2_stored", dev_rd(32'h100), 32'hDEAD);

      // 3: data burst against a constantly waiting fetch
      do_reset();
      lat = 1;
      dm_req = 1; dm_we = 0; dm_addr = 32'h200;
      if_req = 1; if_addr = 32'h300;
      prev_req = 0; first_if = -1;
      for (int i = 0; i < 14; i++) begin
         cyc();
         if (s_mem_req && !prev_req) gq.push_back(s_mem_addr);
         prev_req = s_mem_req;
         if (s_if_ready && first_if < 0) first_if = i;
         if (s_dm_ready)
            chk("t3_dm_rdata", s_dm_rdata, ref_rd(32'h200));
      end
      expg = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h300, 32'h200};
      chk("t3_grant_count_ok", (gq.size() >= 6), 1);
      for (int k = 0; k < 6 && k < gq.size(); k++)
         chk($sformatf("t3_grant%0d", k), gq[k], expg[k]);
      chk("t3_if_cycle", first_if, 9);

      // 4: cancel an in-flight fetch, new PC follows
      do_reset();
      lat = 4; if_req = 1; if_addr = 32'h60;
      cyc();
      cyc();
      chk("t4_c1_addr", s_mem_addr, 32'h60);
      if_cancel = 1; if_addr = 32'h80;
      cyc();
      chk("t4_c2_if_ready", s_if_ready, 0);
      if_cancel = 0;
      cyc();
      chk("t4_c3_latched", s_mem_addr, 32'h60);
      cyc();
      chk("t4_c4_ack", s_mem_ack, 1);
      chk("t4_c4_if_ready", s_if_ready, 0);
      cyc();
      chk("t4_c5_dead", s_mem_req, 0);
      cyc();
      chk("t4_c6_mem_req", s_mem_req, 1);
      chk("t4_c6_addr", s_mem_addr, 32'h80);
      w = 0;
      do begin
         cyc();
         w++;
      end while (!s_if_ready && w < 8);
      chk("t4_ready_seen", s_if_ready, 1);
      chk("t4_rdata", s_if_rdata, ref_rd(32'h80));
      if_req = 0;

      // 5: reset in the middle of a data access
      do_reset();
      lat = 5;
      dm_req = 1; dm_we = 1; dm_addr = 32'h120; dm_wdata = 32'h1234;
      if_req = 1; if_addr = 32'hA0;
      cyc(); cyc(); cyc();
      chk("t5_busy_we", s_mem_we, 1);
      chk("t5_conf_pre", s_conf, 2);
      rst = 1'b1;
      idle_inputs();
      #1;
      chk("t5_mem_req", mem_req, 0);
      chk("t5_mem_we", mem_we, 0);
      chk("t5_mem_addr", mem_addr, 0);
      chk("t5_mem_wdata", mem_wdata, 0);
      chk("t5_dm_ready", dm_ready, 0);
      chk("t5_conf", conflict_cycles, 0);
      @(posedge clk); #1;
      rst = 1'b0; mcnt = 0; conf_model = 0;
      stray = 1;
      cyc();
      chk("t5_stray_dm_ready", s_dm_ready, 0);
      chk("t5_stray_if_ready", s_if_ready, 0);
      stray = 0;
      cyc();
      chk("t5_idle", s_mem_req, 0);
      chk("t5_no_store", dev_mem.exists(32'h120), 0);

      // 6: cancel coincident with ack, and cancel in IDLE
      do_reset();
      lat = 2; if_req = 1; if_addr = 32'h90;
      cyc(); cyc();
      if_cancel = 1;
      cyc();
      chk("t6_ack", s_mem_ack, 1);
      chk("t6_if_ready", s_if_ready, 0);
      if_cancel = 0; if_req = 0;
      cyc();
      chk("t6_mem_req_drop", s_mem_req, 0);
      if_req = 1; if_cancel = 1;
      cyc();
      if_cancel = 0; if_req = 0;
      cyc();
      chk("t6_idle_cancel_blocks", s_mem_req, 0);

      // Randomized traffic against reference memory
      do_reset();
      rand_lat = 1;
      f_act = 0; d_act = 0; f_wait = 0; max_wait = 0;
      prev_req = 0; prev_addr = 0;
      for (int n = 0; n < 800; n++) begin
         if_cancel = 0;
         if (!f_act && $urandom_range(0, 3) == 0) begin
            f_act = 1; f_wait = 0;
            if_addr = 32'($urandom_range(0, 15)) << 2;
         end else if (f_act && $urandom_range(0, 19) == 0) begin
            if_cancel = 1; f_wait = 0;
            if_addr = 32'($urandom_range(0, 15)) << 2;
         end
         if (!d_act && $urandom_range(0, 2) == 0) begin
            d_act = 1;
            dm_we = 1'($urandom_range(0, 1));
            dm_addr = 32'($urandom_range(0, 15)) << 2;
            dm_wdata = $urandom;
         end
         if_req = f_act; dm_req = d_act;
         cyc();
         if (if_cancel) chk("rnd_cancel_ready", s_if_ready, 0);
         if (s_if_ready) begin
            chk("rnd_if_rdata", s_if_rdata, ref_rd(if_addr));
            f_act = 0;
         end
         if (s_dm_ready) begin
            if (dm_we) ref_mem[dm_addr] = dm_wdata;
            else chk("rnd_dm_rdata", s_dm_rdata, ref_rd(dm_addr));
            d_act = 0;
         end
         if (f_act) begin
            f_wait++;
            if (f_wait > max_wait) max_wait = f_wait;
         end
         if (s_mem_req && prev_req)
            chk("rnd_payload_stable", s_mem_addr, prev_addr);
         prev_req = s_mem_req;
         prev_addr = s_mem_addr;
      end
      if_req = 0; dm_req = 0; if_cancel = 0;
      cyc();
      chk("rnd_conflicts", s_conf, conf_model);
      chk("rnd_fetch_progress", (max_wait <= 40), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
